// File: rtl/lrf_frame_packer.sv
// Pixel-to-AXI-Stream frame packer: gathers PIXELS_PER_BEAT pixels per beat,
// buffers beats in a FWFT FIFO and closes broken frames with a zero tlast beat.
module lrf_frame_packer #(
    parameter  int PIXELS_PER_BEAT = 16,
    parameter  int IMAGE_DIM       = 512,
    parameter  int FIFO_DEPTH      = 16,
    localparam int DATA_WIDTH      = 8 * PIXELS_PER_BEAT
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_aresetn,
    input  logic [7:0]            pix_data,
    input  logic                  pix_valid,
    input  logic                  pix_sof,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  overflow,
    output logic                  frame_err,
    output logic                  frame_done
);

    localparam int BEATS_PER_IMAGE = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int LW = $clog2(PIXELS_PER_BEAT);
    localparam int BW = (BEATS_PER_IMAGE > 1) ? $clog2(BEATS_PER_IMAGE) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        WAIT_SOF,
        RUN,
        DROP
    } state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         lane_q, lane_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic                  abort_q, abort_d;

    logic                  set_ovf, set_err;
    logic                  push;
    logic [DATA_WIDTH:0]   push_word;
    logic [DATA_WIDTH-1:0] beat_data;
    logic                  beat_last;
    logic                  abort_reason;
    logic                  abort_push;

    logic [AW:0]           wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
    logic [DATA_WIDTH:0]   head;
    logic                  fifo_empty, fifo_full, pop, can_accept;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = !fifo_empty && m_axis_tready;
    // A pop in the same cycle frees a slot for the incoming push.
    assign can_accept = !fifo_full || pop;

    assign head          = mem[rd_ptr_q[AW-1:0]];
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : head[DATA_WIDTH-1:0];
    assign m_axis_tlast  = !fifo_empty && head[DATA_WIDTH];

    // Next-state, lane assembly, FIFO push selection and abort bookkeeping.
    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        beat_d       = beat_q;
        asm_d        = asm_q;
        abort_d      = abort_q;
        set_ovf      = 1'b0;
        set_err      = 1'b0;
        push         = 1'b0;
        push_word    = '0;
        abort_reason = 1'b0;
        abort_push   = 1'b0;
        beat_data    = asm_q;
        beat_data[8*lane_q +: 8] = pix_data;
        beat_last    = (beat_q == BW'(BEATS_PER_IMAGE - 1));

        // Pending abort beat owns the push port; data beats meeting it are lost.
        if (abort_q && can_accept) begin
            push                 = 1'b1;
            push_word            = '0;
            push_word[DATA_WIDTH] = 1'b1;
            abort_push           = 1'b1;
        end

        if (pix_valid && pix_sof) begin
            if (state_q == RUN && (lane_q != '0 || beat_q != '0)) begin
                set_err      = 1'b1;
                abort_reason = 1'b1;
            end
            asm_d       = asm_q;
            asm_d[7:0]  = pix_data;
            lane_d      = LW'(1);
            beat_d      = '0;
            state_d     = RUN;
        end else if (pix_valid && state_q == RUN) begin
            asm_d  = beat_data;
            lane_d = lane_q + LW'(1);
            if (lane_q == LW'(PIXELS_PER_BEAT - 1)) begin
                beat_d = beat_q + BW'(1);
                if (abort_q || !can_accept) begin
                    set_ovf      = 1'b1;
                    abort_reason = 1'b1;
                    state_d      = beat_last ? WAIT_SOF : DROP;
                end else begin
                    push      = 1'b1;
                    push_word = {beat_last, beat_data};
                    if (beat_last) begin
                        state_d = WAIT_SOF;
                    end
                end
            end
        end

        // A new reason while already pending merges into the existing abort.
        abort_d = abort_q ? !abort_push : abort_reason;
    end

    // Control state, counters, sticky flags and FIFO pointers.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q    <= WAIT_SOF;
            lane_q     <= '0;
            beat_q     <= '0;
            asm_q      <= '0;
            abort_q    <= 1'b0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
            frame_done <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            beat_q     <= beat_d;
            asm_q      <= asm_d;
            abort_q    <= abort_d;
            overflow   <= overflow | set_ovf;
            frame_err  <= frame_err | set_err;
            frame_done <= pop && m_axis_tlast;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // Beat storage; contents are only visible while the FIFO is non-empty.
    always_ff @(posedge s_axis_aclk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= push_word;
        end
    end

endmodule
